uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Parametrised oversampling serial receiver. It recovers asynchronous frames (start, data LSB-first, optional parity, 1-2 stop bits) from rx_data_i and pushes each received word plus error flags into the downstream write FIFO through a write-increment strobe. It adds several features: an input synchroniser, 3-sample majority voting, false-start rejection, parity checking, FIFO-full overrun reporting, and early stop-bit release for back-to-back frames.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
OVERSAMPLE, 16, rx_sclk_i cycles per bit; even, legal 8..32
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, stop bits per frame; legal 1 or 2
SYNC_STAGES, 2, synchroniser flops on rx_data_i; legal 2..3

Ports:
rx_sclk_i  in  1  oversample clock; the block's only clock
rx_arst_n_i  in  1  asynchronous, active-low reset
rx_data_i  in  1  serial line; idles high; asynchronous to rx_sclk_i
wfull_i  in  1  downstream FIFO full
wdata_o  out  DATA_BITS+2  [DATA_BITS-1:0] data, [DATA_BITS] parity_err, [DATA_BITS+1] frame_err
winc_o  out  1  one-cycle FIFO write strobe
overrun_o  out  1  one-cycle pulse: frame dropped because wfull_i was high
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; synchroniser flops=1; wdata_o=0; winc_o=0; overrun_o=0; counters=0. Reset mid-frame abandons the frame with no write.
- All decisions use the synchronised line rxs, which lags rx_data_i by SYNC_STAGES cycles.
- States: IDLE, START, DATA, PARITY, STOP, WRITE. Counter cnt runs 0..OVERSAMPLE-1 within each bit. cnt=0 on the first cycle of each state.
- IDLE -> START only on a falling edge of rxs (previous 1, current 0). A line held low (break) never retriggers.
- Sampling: rxs is captured at cnt = OS/2-1, OS/2 and OS/2+1. The bit value is the majority of the three, decided at cnt=OS/2+1.
- START: a majority-1 result means a false start; go to IDLE at the decision cycle. Otherwise go to DATA when cnt=OS-1.
- DATA: bit_idx counts 0..DATA_BITS-1. Each bit is stored at data[bit_idx]. After the last bit at cnt=OS-1, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: parity_err = XOR(data, parity bit) != PARITY_ODD. parity_err=0 when PARITY_EN=0.
- STOP: frame_err is set if any stop bit's majority is 0. A non-final stop bit ends at cnt=OS-1. The final stop bit goes to WRITE at its decision cycle (cnt=OS/2+1), without waiting for the bit end.
- WRITE (1 cycle):
  - wdata_o is registered with {frame_err, parity_err, data}.
  - winc_o=1 if wfull_i=0. Otherwise winc_o=0, overrun_o=1, and wdata_o is still updated.
  - Next state is IDLE.
- wdata_o holds its value between writes.
- Frames with errors are still written; they are flagged, not dropped.
- Latency: winc_o is high exactly (DATA_BITS+PARITY_EN+STOP_BITS)*OS + OS/2 + 2 cycles after the first START cycle.
- Counters use saturation-free widths: cnt is clog2(OS) bits, bit_idx is clog2(DATA_BITS+1) bits.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE..WRITE)
  - wdata field index constants/functions (PERR_IDX=DATA_BITS, FERR_IDX=DATA_BITS+1)
  - parameter-legality checks
- One sub-module: uart_rx_sync. It contains the SYNC_STAGES flop chain (reset to 1) and the falling-edge detector, with outputs rxs and fall.

Test Plan:
- 8N1, OS=16: send 0xA5 with ideal timing, wfull_i=0 -> one winc_o pulse 154 cycles after the first START cycle; wdata_o=10'h0A5; busy_o low the next cycle.
- 8E1: send 0x03 with the correct parity bit 0, then 0x03 with parity bit 1 -> wdata_o=10'h003, then 10'h103 (parity_err set).
- Stop bit driven 0 on 0x55 -> wdata_o=10'h255 (frame_err set). Line held low 300 cycles afterwards -> no further winc_o until the line goes high and then falls again.
- 4-cycle low glitch on an idle line -> START is entered, then rejected at majority; no winc_o, busy_o returns low. A single-cycle flipped sample mid-data bit -> data unaffected.
- wfull_i=1 during WRITE for 0x3C -> winc_o stays 0; overrun_o pulses 1 cycle; wdata_o=10'h03C.
- Async reset asserted mid-DATA, released, then a full frame 0x81 sent -> no write for the aborted frame; the next frame is written as 10'h081.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// State encoding, wdata field indices and parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_WRITE  = 3'd5
  } state_e;

  function automatic int perr_idx(input int db);
    return db;
  endfunction

  function automatic int ferr_idx(input int db);
    return db + 1;
  endfunction

  function automatic bit params_ok(
    input int db,
    input int os,
    input int pe,
    input int po,
    input int sb,
    input int ss
  );
    return (db >= 5) && (db <= 9) &&
           (os >= 8) && (os <= 32) && (os % 2 == 0) &&
           (pe >= 0) && (pe <= 1) &&
           (po >= 0) && (po <= 1) &&
           (sb >= 1) && (sb <= 2) &&
           (ss >= 2) && (ss <= 3);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser chain (resets to idle-high) plus falling-edge detect.
// Ports: clk_i, rst_ni, d_i (async line) -> rxs_o (synced), fall_o.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rxs_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign rxs_o  = chain_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver writing {ferr, perr, data} into a FIFO.
// Ports: rx_sclk_i, rx_arst_n_i, rx_data_i, wfull_i -> wdata_o, winc_o, overrun_o, busy_o.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rx_sclk_i,
  input  logic                 rx_arst_n_i,
  input  logic                 rx_data_i,
  input  logic                 wfull_i,
  output logic [DATA_BITS+1:0] wdata_o,
  output logic                 winc_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  if (!params_ok(DATA_BITS, OVERSAMPLE, PARITY_EN,
                 PARITY_ODD, STOP_BITS, SYNC_STAGES)) begin : g_bad_params
    $error("uart_rx_os: illegal parameter set");
  end

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int MID = OVERSAMPLE / 2;
  localparam int PI  = perr_idx(DATA_BITS);
  localparam int FI  = ferr_idx(DATA_BITS);

  localparam logic [CW-1:0] C_S0  = CW'(MID - 1);
  localparam logic [CW-1:0] C_S1  = CW'(MID);
  localparam logic [CW-1:0] C_DEC = CW'(MID + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LST = BW'(DATA_BITS - 1);

  logic rxs;
  logic fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (rx_sclk_i),
    .rst_ni(rx_arst_n_i),
    .d_i   (rx_data_i),
    .rxs_o (rxs),
    .fall_o(fall)
  );

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS+1:0]   wdata_q, wdata_d;

  logic maj;
  logic dec;
  logic last_stop;

  // Third sample is the live rxs on the decision cycle.
  assign maj = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign dec = (cnt_q == C_DEC);
  assign last_stop = (STOP_BITS == 1) || stop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stop_d  = stop_q;
    wdata_d = wdata_q;

    if (cnt_q == C_S0) s0_d = rxs;
    if (cnt_q == C_S1) s1_d = rxs;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = ST_START;
          bit_d   = '0;
          data_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          stop_d  = 1'b0;
        end
      end
      ST_START: begin
        if (dec && maj) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_END) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (dec) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_q == BW'(i)) data_d[i] = maj;
          end
        end
        if (cnt_q == C_END) begin
          cnt_d = '0;
          if (bit_q == B_LST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (dec) begin
          perr_d = ((^data_q) ^ maj) != (PARITY_ODD != 0);
        end
        if (cnt_q == C_END) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end
      end
      ST_STOP: begin
        if (dec) begin
          if (!maj) ferr_d = 1'b1;
          // Final stop bit releases early so a following start is not missed.
          if (last_stop) begin
            state_d                   = ST_WRITE;
            cnt_d                     = '0;
            wdata_d[DATA_BITS-1:0]    = data_q;
            wdata_d[PI]               = perr_q;
            wdata_d[FI]               = ferr_q | ~maj;
          end
        end else if (cnt_q == C_END) begin
          stop_d = 1'b1;
          cnt_d  = '0;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rx_sclk_i or negedge rx_arst_n_i) begin
    if (!rx_arst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stop_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stop_q  <= stop_d;
      wdata_q <= wdata_d;
    end
  end

  assign wdata_o   = wdata_q;
  assign winc_o    = (state_q == ST_WRITE) & ~wfull_i;
  assign overrun_o = (state_q == ST_WRITE) & wfull_i;
  assign busy_o    = (state_q != ST_IDLE);

endmodule
